imem_load_arbiter: RTL and testbench

//  Owns the single port of a synchronous-read instruction RAM and shares it between a program loader
//  and the IF stage. After reset it streams a program image from the loader into the RAM and zero-fills
//  the rest. It then hands the port to fetch and raises cpu_run. A reload request drains any outstanding

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_fetch_path.sv | 34 +++
 rtl/imem_load_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_load_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD,
        FILL,
        RUN,
        DRAIN
    } imem_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_path.sv
// Fetch return path: turns a grant into fetch_valid one cycle later and
// substitutes a NOP when the granted PC did not touch the RAM.
module imem_fetch_path
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnt,
    input  logic        pc_ok,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst
);

    logic valid_q;
    logic from_ram_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            from_ram_q <= 1'b0;
        end else begin
            valid_q    <= gnt;
            from_ram_q <= gnt & pc_ok;
        end
    end

    // RAM data arrives in the cycle after the read, so it is muxed, not registered.
    assign fetch_valid = valid_q;
    assign fetch_inst  = from_ram_q ? mem_rdata : INST_NOP;

endmodule

// File: rtl/imem_load_arbiter.sv
// Single-port instruction RAM owner: loads a program image, zero-fills the
// remainder, then serves IF-stage fetches until a reload is requested.
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter  int NUM_INST = 128,
    localparam int ADDR_W   = $clog2(NUM_INST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_inst,
    output logic              cpu_run,
    output logic              load_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INST - 1);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              load_err_q, load_err_d;
    logic              ld_ready_q;
    logic              ld_fire;
    logic              pc_ok;

    assign ld_fire = ld_valid & ld_ready_q & (state_q == LOAD);

    // Word-aligned and inside the RAM; anything else returns a NOP.
    assign pc_ok = (fetch_pc[1:0] == 2'b00) && (fetch_pc[31:ADDR_W+2] == '0);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_err_d = load_err_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = INST_NOP;
        fetch_gnt  = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (ld_fire) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q;
                    mem_wdata = ld_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = RUN;
                        if (!ld_last) load_err_d = 1'b1;
                    end else if (ld_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = RUN;
            end
            RUN: begin
                fetch_gnt = fetch_req;
                if (fetch_req && pc_ok) begin
                    mem_en   = 1'b1;
                    mem_addr = fetch_pc[ADDR_W+1:2];
                end
                if (load_start) state_d = DRAIN;
            end
            DRAIN: begin
                state_d    = LOAD;
                cnt_d      = '0;
                load_err_d = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    // ld_ready is registered from the next state so it stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            load_err_q <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
            ld_ready_q <= (state_d == LOAD);
        end
    end

    assign ld_ready = ld_ready_q;
    assign cpu_run  = (state_q == RUN);
    assign load_err = load_err_q;

    imem_fetch_path u_fetch_path (
        .clk         (clk),
        .rst_n       (rst_n),
        .gnt         (fetch_gnt),
        .pc_ok       (pc_ok),
        .mem_rdata   (mem_rdata),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst)
    );

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter with an 8-word RAM model.
module tb_imem_load_arbiter;

    localparam int N = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_inst;
    logic          cpu_run;
    logic          load_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    imem_load_arbiter #(.NUM_INST(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .cpu_run     (cpu_run),
        .load_err    (load_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    localparam logic [31:0] WA = 32'hA000_000A;
    localparam logic [31:0] WB = 32'hB000_000B;
    localparam logic [31:0] WC = 32'hC000_000C;
    localparam logic [31:0] WE = 32'hE000_000E;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [31:0] inst;
        int          cyc;
    } rd_t;

    wr_t wq[$];
    rd_t fq[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    logic [31:0] ram [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read single-port RAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitors: every RAM write and every fetch result is popped against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mem_en && mem_we) begin
            if (wq.size() == 0) begin
                fail_now($sformatf("unexpected_write addr=%0d data=%h", mem_addr, mem_wdata));
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (fetch_valid) begin
            if (fq.size() == 0) begin
                fail_now($sformatf("unexpected_fetch_valid inst=%h", fetch_inst));
            end else begin
                rd_t r;
                r = fq.pop_front();
                check("fetch_inst", fetch_inst, r.inst);
                check("fetch_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        wq.push_back(e);
    endtask

    task automatic check_reset_vals();
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_fetch_gnt", 32'(fetch_gnt), 0);
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_fetch_inst", fetch_inst, 0);
        check("rst_cpu_run", 32'(cpu_run), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
    endtask

    // Present one loader word; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] data, input logic last);
        bit ok = 0;
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ld_ready;
        end
        if (!ok) fail_now("ld_ready_timeout");
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_run();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = cpu_run;
        end
        check("cpu_run_rise", 32'(cpu_run), 1);
        check("writes_done_at_run", 32'(wq.size()), 0);
    endtask

    // Issue one fetch at the current cycle; the result is due one cycle later.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input logic exp_en);
        rd_t r;
        fetch_req = 1'b1;
        fetch_pc  = pc;
        r.inst    = exp;
        r.cyc     = cyc + 1;
        fq.push_back(r);
        @(negedge clk);
        check("fetch_gnt", 32'(fetch_gnt), 1);
        check("fetch_mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) check("fetch_mem_addr", 32'(mem_addr), 32'(pc[AW+1:2]));
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        fetch_req  = 1'b0;
        fetch_pc   = '0;

        repeat (2) @(negedge clk);
        check_reset_vals();
        tick();
        rst_n = 1'b1;

        // Short image with ld_last, then zero fill up to the top word.
        push_wr(0, WA);
        push_wr(1, WB);
        push_wr(2, WC);
        for (int a = 3; a < N; a++) push_wr(a, 32'h0);
        send_word(WA, 1'b0);
        send_word(WB, 1'b0);
        send_word(WC, 1'b1);
        wait_run();
        check("t1_load_err", 32'(load_err), 0);
        check("t1_ld_ready", 32'(ld_ready), 0);

        // Back-to-back fetches.
        tick();
        fetch(32'h0, WA, 1'b1);
        fetch(32'h4, WB, 1'b1);
        fetch(32'h8, WC, 1'b1);
        fetch_req = 1'b0;
        tick();
        tick();

        // Misaligned and out-of-range PCs return NOP without a RAM access.
        fetch(32'h6, 32'h0, 1'b0);
        fetch(32'h400, 32'h0, 1'b0);
        fetch_req = 1'b0;
        tick();
        tick();

        // Reload while a fetch is being granted.
        load_start = 1'b1;
        fetch(32'h4, WB, 1'b1);
        load_start = 1'b0;
        fetch_req  = 1'b1;
        fetch_pc   = 32'h8;
        @(negedge clk);
        check("drain_cpu_run", 32'(cpu_run), 0);
        check("drain_no_gnt", 32'(fetch_gnt), 0);
        check("drain_no_mem_en", 32'(mem_en), 0);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("reload_ld_ready", 32'(ld_ready), 1);
        check("reload_load_err", 32'(load_err), 0);
        check("reload_cpu_run", 32'(cpu_run), 0);

        // Full image without ld_last overflows and flags load_err.
        tick();
        for (int i = 0; i < N; i++) begin
            push_wr(i, 32'h5000_0000 + 32'(i));
            send_word(32'h5000_0000 + 32'(i), 1'b0);
        end
        @(negedge clk);
        check("t2_cpu_run", 32'(cpu_run), 1);
        check("t2_load_err", 32'(load_err), 1);
        check("t2_ld_ready", 32'(ld_ready), 0);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_ld_ready_held_low", 32'(ld_ready), 0);
        end
        ld_valid = 1'b0;
        tick();
        fetch(32'h1C, 32'h5000_0007, 1'b1);
        fetch_req = 1'b0;
        tick();

        // A reload clears the sticky error on LOAD entry.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        @(negedge clk);
        check("clr_load_err", 32'(load_err), 0);
        check("clr_ld_ready", 32'(ld_ready), 1);

        // Reset in the middle of FILL, once the fill has reached cnt=5.
        tick();
        push_wr(0, WA);
        push_wr(1, WB);
        push_wr(2, WC);
        push_wr(3, 32'h0);
        push_wr(4, 32'h0);
        send_word(WA, 1'b0);
        send_word(WB, 1'b0);
        send_word(WC, 1'b1);
        tick();
        tick();
        check("t6_fill_addr5", 32'(mem_addr), 5);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        check("t6_writes_before_reset", 32'(wq.size()), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reload after reset starts at address 0 and rewrites the whole RAM.
        push_wr(0, WE);
        for (int a = 1; a < N; a++) push_wr(a, 32'h0);
        send_word(WE, 1'b1);
        wait_run();
        tick();
        fetch(32'h0, WE, 1'b1);
        fetch(32'h4, 32'h0, 1'b1);
        fetch_req = 1'b0;
        tick();
        tick();

        check("final_wq_empty", 32'(wq.size()), 0);
        check("final_fq_empty", 32'(fq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
